axi_dma_mover: RTL and testbench
================================

AXI_DMA_MOVER -- requirements
Module: axi_dma_mover

Interface
REQ-001 SHALL clock on single clock clk; reset rst SHALL be asynchronous, active-high.
REQ-002 Parameter ID_WIDTH, default 4, AXI ID width; arid/awid driven constant 0.
REQ-003 Parameter MAX_BEATS, default 4, max burst beats and depth of internal beat buffer (power of 2, 1..16).
REQ-004 clk  in  1  clock.
REQ-005 rst  in  1  async active-high reset.
REQ-006 start  in  1  one-cycle pulse; sampled only in IDLE.
REQ-007 src_addr  in  32  source byte address, 4-byte aligned.
REQ-008 dst_addr  in  32  destination byte address, 4-byte aligned.
REQ-009 byte_len  in  16  transfer length in bytes, multiple of 4.
REQ-010 done  out  1  one-cycle pulse at end of transfer.
REQ-011 arid  out  ID_WIDTH  read ID.
REQ-012 araddr  out  32  read burst address.
REQ-013 arlen  out  4  read beats minus 1.
REQ-014 arvalid  out  1  AR valid.
REQ-015 arready  in  1  AR ready.
REQ-016 rdata  in  32  read data.
REQ-017 rlast  in  1  last read beat.
REQ-018 rvalid  in  1  R valid.
REQ-019 rready  out  1  R ready.
REQ-020 awid  out  ID_WIDTH  write ID.
REQ-021 awaddr  out  32  write burst address.
REQ-022 awlen  out  4  write beats minus 1.
REQ-023 awvalid  out  1  AW valid.
REQ-024 awready  in  1  AW ready.
REQ-025 wdata  out  32  write data.
REQ-026 wstrb  out  4  byte strobes, constant 4'hF.
REQ-027 wlast  out  1  last write beat.
REQ-028 wvalid  out  1  W valid.
REQ-029 wready  in  1  W ready.
REQ-030 bvalid  in  1  B valid.
REQ-031 bready  out  1  B ready.

Function
REQ-032 SHALL implement FSM IDLE -> RREQ -> RDATA -> WREQ -> WDATA -> WRESP -> (RREQ if bytes remain, else DONE) -> IDLE; DONE lasts exactly one cycle with done=1.
REQ-033 On start in IDLE SHALL latch src, dst, remaining=byte_len; byte_len=0 SHALL go directly to DONE (no AXI traffic).
REQ-034 Burst beats = min(remaining/4, MAX_BEATS); arlen=awlen=beats-1, identical within one burst iteration.
REQ-035 RREQ: arvalid=1 with araddr=src; held stable until arready; on handshake go RDATA.
REQ-036 RDATA: rready=1; each rvalid beat written to buffer at index 0..beats-1; after beat index beats-1 accepted go WREQ (rlast not required for exit).
REQ-037 WREQ: awvalid=1 with awaddr=dst until awready; then WDATA with beat pointer 0.
REQ-038 WDATA: wvalid=1, wdata=buffer[ptr], wlast=(ptr==beats-1); ptr advances only on wvalid&wready; after last beat go WRESP.
REQ-039 WRESP: bready=1; on bvalid src+=4*beats, dst+=4*beats, remaining-=4*beats (32/16-bit wrap, no saturation).
REQ-040 Only one AXI transaction outstanding; valid signals SHALL never deassert before handshake; bresp/rresp ignored.
REQ-041 start outside IDLE SHALL be ignored.

Reset
REQ-042 On rst: state IDLE, done, arvalid, rready, awvalid, wvalid, wlast, bready = 0; araddr, awaddr, arlen, awlen, wdata = 0; rst mid-transfer aborts immediately, no completion of burst.

Verification
REQ-043 start, src=0x0000, dst=0x1000, byte_len=16, slave preloaded -> one AR (arlen=3), one AW (awlen=3), 4 W beats, wlast on 4th, done pulse; dst bytes equal src.
REQ-044 byte_len=40, MAX_BEATS=4 -> bursts of 4,4,2 beats (arlen 3,3,1), addresses stepping 0x10, single done.
REQ-045 byte_len=0 -> done one cycle after start detection (two cycles post start), no arvalid/awvalid.
REQ-046 arready/awready delayed 3 cycles, AR-to-R delay 50, wready toggling -> address/data held stable, correct data, no dropped beat.
REQ-047 rst asserted during WDATA -> all valids 0 same cycle, FSM IDLE; subsequent start completes normally.
REQ-048 start pulsed during active transfer -> ignored; exactly one done.

Source files
------------

// File: rtl/axi_dma_mover.sv
// Single-channel AXI memory-to-memory mover: read a burst into a local beat
// buffer, write it back out, repeat until the byte count is exhausted.
module axi_dma_mover #(
  parameter int unsigned ID_WIDTH  = 4,
  parameter int unsigned MAX_BEATS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         src_addr,
  input  logic [31:0]         dst_addr,
  input  logic [15:0]         byte_len,
  output logic                done,
  output logic [ID_WIDTH-1:0] arid,
  output logic [31:0]         araddr,
  output logic [3:0]          arlen,
  output logic                arvalid,
  input  logic                arready,
  input  logic [31:0]         rdata,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  output logic [ID_WIDTH-1:0] awid,
  output logic [31:0]         awaddr,
  output logic [3:0]          awlen,
  output logic                awvalid,
  input  logic                awready,
  output logic [31:0]         wdata,
  output logic [3:0]          wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  output logic                bready
);

  localparam int unsigned PW    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int unsigned DEPTH = 2 ** PW;

  typedef enum logic [2:0] {IDLE, RREQ, RDATA, WREQ, WDATA, WRESP, DONE} state_t;

  state_t         state, state_nx;
  logic [31:0]    src, dst;
  logic [15:0]    remaining;
  logic [3:0]     len;
  logic [PW-1:0]  ptr;
  logic [31:0]    buffer [DEPTH];
  logic           last_beat;
  logic [15:0]    step;
  logic [15:0]    rem_after;
  logic           unused_rlast;

  // Beats-minus-one for the next burst; remainders below one word end the transfer.
  function automatic logic [3:0] burst_len(input logic [15:0] rem);
    logic [13:0] words;
    words = rem[15:2];
    if (words == '0)                     return '0;
    else if (words >= 14'(MAX_BEATS))    return 4'(MAX_BEATS - 1);
    else                                 return 4'(words - 14'd1);
  endfunction

  assign step         = {9'd0, 5'({1'b0, len} + 5'd1), 2'b00};
  assign rem_after    = remaining - step;
  assign last_beat    = (4'(ptr) == len);
  assign unused_rlast = rlast;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = (byte_len[15:2] == '0) ? DONE : RREQ;
      RREQ:    if (arready) state_nx = RDATA;
      RDATA:   if (rvalid && last_beat) state_nx = WREQ;
      WREQ:    if (awready) state_nx = WDATA;
      WDATA:   if (wready && last_beat) state_nx = WRESP;
      WRESP:   if (bvalid) state_nx = (rem_after[15:2] != '0) ? RREQ : DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      len       <= '0;
      ptr       <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (start) begin
          src       <= src_addr;
          dst       <= dst_addr;
          remaining <= byte_len;
          len       <= burst_len(byte_len);
          ptr       <= '0;
        end
        RDATA: if (rvalid) ptr <= last_beat ? '0 : ptr + PW'(1);
        WDATA: if (wready) ptr <= last_beat ? '0 : ptr + PW'(1);
        WRESP: if (bvalid) begin
          src       <= src + 32'(step);
          dst       <= dst + 32'(step);
          remaining <= rem_after;
          len       <= burst_len(rem_after);
        end
        default: ;
      endcase
    end
  end

  // Beat storage carries no reset; wdata is gated so it reads zero outside WDATA.
  always_ff @(posedge clk) begin
    if (state == RDATA && rvalid) buffer[ptr] <= rdata;
  end

  assign arid    = '0;
  assign awid    = '0;
  assign araddr  = src;
  assign awaddr  = dst;
  assign arlen   = len;
  assign awlen   = len;
  assign arvalid = (state == RREQ);
  assign rready  = (state == RDATA);
  assign awvalid = (state == WREQ);
  assign wvalid  = (state == WDATA);
  assign wdata   = (state == WDATA) ? buffer[ptr] : '0;
  assign wlast   = (state == WDATA) && last_beat;
  assign wstrb   = '1;
  assign bready  = (state == WRESP);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_axi_dma_mover.sv
// Bench for axi_dma_mover: AXI slave memory with adjustable latencies, and a
// burst-list reference model of the copy checked channel by channel.
module tb_axi_dma_mover;
  localparam int unsigned IDW = 4;
  localparam int unsigned MB  = 4;

  logic clk = 1'b0;
  logic rst, start, done;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] byte_len;
  logic [IDW-1:0] arid, awid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [3:0]  arlen, awlen, wstrb;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  axi_dma_mover #(.ID_WIDTH(IDW), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .byte_len(byte_len), .done(done), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bvalid(bvalid), .bready(bready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] mem     [4096];
  logic [31:0] ref_mem [4096];
  logic [35:0] exp_ar[$];
  logic [35:0] exp_aw[$];
  logic [32:0] exp_w[$];

  int unsigned ar_dly = 0, aw_dly = 0, r_dly = 0;
  bit          w_toggle = 1'b0;
  int unsigned done_cnt = 0, av_cnt = 0;

  function automatic int unsigned widx(input logic [31:0] a);
    return {20'd0, a[13:2]};
  endfunction

  // Slave state, owned by the slave process only
  bit          ar_hs, r_hs, aw_hs, w_hs, b_hs, ar_pend, aw_pend, w_pend;
  logic [35:0] ar_cap, aw_cap;
  logic [32:0] w_cap;
  bit          r_active, b_pend;
  logic [31:0] r_addr, w_addr;
  int unsigned r_len, r_beat, r_wait, w_beat, ar_cnt, aw_cnt;

  // Inputs change on the falling edge; handshakes are predicted there and
  // retired on the next falling edge (DUT outputs are state-only).
  initial begin
    arready = 0; rvalid = 0; rdata = '0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (arvalid || awvalid) av_cnt++;
      if (rst) begin
        arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
        ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        ar_pend = 0; aw_pend = 0; w_pend = 0; r_active = 0; b_pend = 0;
        ar_cnt = 0; aw_cnt = 0;
        continue;
      end
      if (ar_pend) chk("ar_valid_held", arvalid, 1);
      if (aw_pend) chk("aw_valid_held", awvalid, 1);
      if (w_pend)  chk("w_valid_held", wvalid, 1);
      if (ar_hs) begin
        arready = 0; ar_cnt = 0; r_active = 1;
        r_addr = ar_cap[35:4]; r_len = ar_cap[3:0]; r_beat = 0; r_wait = r_dly;
        if (exp_ar.size() > 0) void'(exp_ar.pop_front());
      end
      if (r_hs) begin
        rvalid = 0; rlast = 0; r_beat++;
        if (r_beat > r_len) r_active = 0;
      end
      if (aw_hs) begin
        awready = 0; aw_cnt = 0; w_addr = aw_cap[35:4]; w_beat = 0;
        if (exp_aw.size() > 0) void'(exp_aw.pop_front());
      end
      if (w_hs) begin
        mem[(widx(w_addr) + w_beat) % 4096] = w_cap[32:1];
        w_beat++;
        if (w_cap[0]) b_pend = 1;
        if (exp_w.size() > 0) void'(exp_w.pop_front());
      end
      if (b_hs) begin bvalid = 0; b_pend = 0; end
      if (arvalid) begin
        if (exp_ar.size() == 0) chk("ar_unexpected", 1, 0);
        else chk("ar_addr_len", {araddr, arlen}, exp_ar[0]);
      end
      if (awvalid) begin
        if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
        else chk("aw_addr_len", {awaddr, awlen}, exp_aw[0]);
      end
      if (wvalid) begin
        if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
        else chk("w_data_last", {wdata, wlast}, exp_w[0]);
      end
      if (arvalid && !arready) begin
        if (ar_cnt >= ar_dly) arready = 1; else ar_cnt++;
      end
      if (r_active && !rvalid) begin
        if (r_wait > 0) r_wait--;
        else begin
          rvalid = 1;
          rdata  = mem[(widx(r_addr) + r_beat) % 4096];
          rlast  = (r_beat == r_len);
        end
      end
      if (awvalid && !awready) begin
        if (aw_cnt >= aw_dly) awready = 1; else aw_cnt++;
      end
      wready = wvalid ? (w_toggle ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
      if (b_pend && !bvalid) bvalid = 1;
      ar_hs = arvalid && arready; ar_cap = {araddr, arlen}; ar_pend = arvalid && !ar_hs;
      aw_hs = awvalid && awready; aw_cap = {awaddr, awlen}; aw_pend = awvalid && !aw_hs;
      w_hs  = wvalid && wready;   w_cap  = {wdata, wlast};  w_pend  = wvalid && !w_hs;
      r_hs  = rvalid && rready;
      b_hs  = bvalid && bready;
    end
  end

  // Expected burst list: word-count chunks of at most MB beats, addresses advancing per chunk.
  task automatic push_expect(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len);
    int unsigned rem, b;
    rem = len;
    while (rem >= 4) begin
      b = (rem / 4 > MB) ? MB : rem / 4;
      exp_ar.push_back({s, 4'(b - 1)});
      exp_aw.push_back({d, 4'(b - 1)});
      for (int unsigned i = 0; i < b; i++)
        exp_w.push_back({ref_mem[(widx(s) + i) % 4096], (i == b - 1)});
      s += 4 * b; d += 4 * b; rem -= 4 * b;
    end
  endtask

  task automatic mem_compare(input string tag);
    int unsigned mism = 0;
    for (int unsigned i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) mism++;
    chk(tag, mism, 0);
  endtask

  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] len,
                          input bit poke, output int unsigned lat);
    int unsigned d0;
    bit got;
    d0 = done_cnt;
    push_expect(s, d, len);
    @(negedge clk);
    src_addr = s; dst_addr = d; byte_len = len; start = 1;
    lat = 0; got = 0;
    while (lat < 3000 && !got) begin
      @(posedge clk); #1;
      lat++;
      if (poke && lat == 6) begin
        start = 1; src_addr = 32'h0500; dst_addr = 32'h3C00; byte_len = 16'd8;
      end else start = 0;
      if (done) got = 1;
    end
    start = 0;
    chk("done_seen", got, 1);
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", done_cnt - d0, 1);
    chk("queues_drained", {16'(exp_ar.size()), 16'(exp_aw.size()), 16'(exp_w.size())}, 0);
    for (int unsigned k = 0; k < len / 4; k++)
      ref_mem[(widx(d) + k) % 4096] = ref_mem[(widx(s) + k) % 4096];
    mem_compare("mem_image");
  endtask

  int unsigned lat, a0, d0;
  logic [31:0] rs, rd;
  logic [15:0] rl;

  initial begin
    rst = 1; start = 0; src_addr = '0; dst_addr = '0; byte_len = '0;
    for (int unsigned i = 0; i < 4096; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {done, arvalid, rready, awvalid, wvalid, wlast, bready}, 0);
    chk("rst_addr", {araddr, awaddr}, 0);
    chk("rst_len_data", {arlen, awlen, wdata}, 0);
    chk("const_ids_strb", {arid, awid, wstrb}, {8'h00, 4'hF});
    @(negedge clk); rst = 0;

    run_xfer(32'h0000, 32'h1000, 16'd16, 0, lat);
    run_xfer(32'h0100, 32'h2100, 16'd40, 0, lat);

    a0 = av_cnt;
    run_xfer(32'h0040, 32'h2040, 16'd0, 0, lat);
    chk("zero_len_latency", lat, 1);
    chk("zero_len_no_traffic", av_cnt - a0, 0);

    ar_dly = 3; aw_dly = 3; r_dly = 50; w_toggle = 1;
    run_xfer(32'h0200, 32'h2400, 16'd40, 0, lat);
    ar_dly = 0; aw_dly = 0; r_dly = 0; w_toggle = 0;

    run_xfer(32'h0300, 32'h2800, 16'd48, 1, lat);

    // Abort mid-write: destination pre-filled with source data so partial writes are invisible.
    for (int unsigned k = 0; k < 8; k++) begin
      mem[widx(32'h3800) + k] = mem[widx(32'h3000) + k];
      ref_mem[widx(32'h3800) + k] = ref_mem[widx(32'h3000) + k];
    end
    w_toggle = 1;
    d0 = done_cnt;
    push_expect(32'h3000, 32'h3800, 16'd32);
    @(negedge clk);
    src_addr = 32'h3000; dst_addr = 32'h3800; byte_len = 16'd32; start = 1;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      start = 0;
      if (wvalid) break;
    end
    chk("reached_wdata", wvalid, 1);
    rst = 1;
    #1;
    chk("abort_ctrl", {done, arvalid, rready, awvalid, wvalid, wlast, bready}, 0);
    chk("abort_wdata", wdata, 0);
    repeat (2) @(negedge clk);
    exp_ar.delete(); exp_aw.delete(); exp_w.delete();
    @(negedge clk); rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    mem_compare("abort_mem_image");
    w_toggle = 0;
    run_xfer(32'h0400, 32'h2C00, 16'd24, 0, lat);

    for (int t = 0; t < 6; t++) begin
      ar_dly = $urandom_range(0, 3); aw_dly = $urandom_range(0, 3);
      r_dly = $urandom_range(0, 5);  w_toggle = 1'($urandom_range(0, 1));
      rs = {18'd0, 12'($urandom_range(0, 900)), 2'b00};
      rd = 32'h2000 + {18'd0, 12'($urandom_range(0, 900)), 2'b00};
      rl = 16'(4 * $urandom_range(0, 24));
      run_xfer(rs, rd, rl, 1'($urandom_range(0, 1)), lat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
